lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Sequential load/store unit for the lx32 core that replaces the pass-through LSU. It accepts one memory request at a time from the execute stage and drives a word-aligned, byte-enabled memory bus with a ready/ack handshake. It handles byte and halfword lane steering, sign/zero extension of loads, and wait states with a timeout. It returns a single-cycle response pulse to the writeback stage.

## Interface
- WIDTH, 32, data/address width; legal values 32 or 64 (byte lanes = WIDTH/8)
- MAX_WAIT, 16, maximum bus wait cycles before a timeout error; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe from execute
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110)
- alu_result  in  WIDTH  effective byte address
- write_data  in  WIDTH  store data (LSBs significant)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3, bus error or timeout (valid with resp_valid)
- mem_req  out  1  bus request, held until terminated
- mem_addr  out  WIDTH  address aligned down to WIDTH/8
- mem_we  out  1  write enable
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_be  out  WIDTH/8  byte enables
- mem_ack  in  1  bus completion
- mem_err  in  1  bus error completion
- mem_rdata  in  WIDTH  read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- IDLE: req_ready=1. On req_valid, latch all request fields.
  - If the request is illegal or trapping, go to RESP with err=1.
  - Otherwise go to BUS.
- Illegal requests:
  - D, WU when WIDTH=32.
  - Loads with funct3 111.
  - Stores with funct3 ≥ 100 (WIDTH=32) or ≥ 100 (WIDTH=64, since stores use only 000–011).
- BUS:
  - mem_req=1, and mem_addr/mem_we/mem_wdata/mem_be are stable.
  - Terminate on mem_ack or mem_err, then go to RESP.
  - Wait counter: reset on entry; increments each BUS cycle without termination.
  - Timeout: when counter == MAX_WAIT-1 and no termination (MAX_WAIT≠0), go to RESP with err=1.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in BUS and RESP.
- Byte offset: off = alu_result[log2(WIDTH/8)-1:0].
- Store lanes:
  - B: wdata = byte replicated across all lanes, be = 1<<off.
  - H: wdata = half replicated, be = 2'b11<<off.
  - W: word replicated, be = 4'hF<<off.
  - D: full width, be = all ones.
- Loads: mem_we=0, be as for the same size. Data = mem_rdata >> (8·off), truncated to the size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU/D).
- Termination priority: mem_err wins over mem_ack in the same cycle; err=1, rdata=0.
- mem_ack/mem_err outside BUS are ignored.
- req_valid outside IDLE is ignored (no queueing).

## Timing
- Reset (asynchronous): every output goes to 0 immediately, except req_ready, which is 1 once the FSM is in IDLE (combinational from state). An in-flight mem_req is dropped with no response.
- Accept at edge N; mem_req is high in cycle N+1.
- Zero-wait ack in cycle N+1 gives resp_valid in cycle N+2. Each wait state adds 1 cycle.
- Error/trap path with no bus access: resp_valid in cycle N+1, and mem_req never asserts.
- Timeout: mem_req is high for exactly MAX_WAIT cycles, then resp_valid with err=1.
- Next acceptance is possible in the cycle after resp_valid (IDLE).

## Configuration
- LSU_MISALIGN_TRAP_EN defined: an access not naturally aligned (H with off[0]≠0, W with off[1:0]≠0, D with off≠0) returns err=1 via the trap path, with no bus access.
- Not defined: misaligned low address bits are forced to natural alignment (cleared) and the access proceeds normally with err=0.

## Test plan
- SW to 0x10, data 0xDEADBEEF, ack in cycle 1 -> mem_addr=0x10, be=4'hF, mem_we=1; resp_valid 2 cycles after accept with err=0, rdata=0.
- SB to 0x13, data 0x000000A5 -> be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10.
- LB at 0x12 with rdata=0x0080FF00 -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x12 -> 0x00000080.
- LW with 3 wait states -> mem_req held 4 cycles and resp 5 cycles after accept. MAX_WAIT=4 with no ack -> mem_req held 4 cycles, then err=1.
- LH at 0x11: with LSU_MISALIGN_TRAP_EN -> err=1 the next cycle and mem_req never high. Without it -> access at be=4'b0011, err=0.
- rst asserted during BUS -> mem_req drops the same instant, no resp_valid, and a new request is accepted after release. Simultaneous mem_ack and mem_err -> err=1, rdata=0.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-bus bundle for lsu_mem_ctrl.
// master: the LSU side (req_ready, resp_*, mem_req/addr/we/wdata/be out).
// slave: execute/writeback plus memory (req_*, mem_ack/err/rdata out).
interface lsu_mem_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [2:0]         req_funct3;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   write_data;

    logic               resp_valid;
    logic [WIDTH-1:0]   resp_rdata;
    logic               resp_err;

    logic               mem_req;
    logic [WIDTH-1:0]   mem_addr;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH/8-1:0] mem_be;
    logic               mem_ack;
    logic               mem_err;
    logic [WIDTH-1:0]   mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3,
               alu_result, write_data,
               mem_ack, mem_err, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
               resp_err, mem_req, mem_addr,
               mem_we, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_write, req_funct3,
               alu_result, write_data,
               mem_ack, mem_err, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
               resp_err, mem_req, mem_addr,
               mem_we, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit: one request at a time, byte-enabled bus,
// lane steering, load extension, wait-state timeout, 1-cycle response.
// Ports: clk, rst (async, active high), bus (lsu_mem_ctrl_if.master).
// Params: WIDTH (32/64), MAX_WAIT (bus wait limit, 0 = no timeout).
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them down.
module lsu_mem_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.master bus
);
    localparam int NB = WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [WIDTH-1:0] M_B = WIDTH'(8'hFF);
    localparam logic [WIDTH-1:0] M_H = WIDTH'(16'hFFFF);
    localparam logic [WIDTH-1:0] M_W = WIDTH'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    // decode of the live request, consumed only on accept
    logic [1:0]       sz;
    logic             uns;
    logic [OW-1:0]    off;
    logic [OW-1:0]    amask;
    logic [OW-1:0]    aoff;
    logic             illegal;
    logic             trap;
    logic [NB-1:0]    be_base;
    logic [NB-1:0]    be_nx;
    logic [WIDTH-1:0] wdata_nx;
    logic [WIDTH-1:0] addr_nx;

    // latched request
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [NB-1:0]    be_q;
    logic             we_q;
    logic [1:0]       sz_q;
    logic             uns_q;
    logic [OW-1:0]    off_q;
    logic [CW-1:0]    wcnt;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;

    // load path
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lmask;
    logic             lsign;
    logic [WIDTH-1:0] ldata;

    logic accept;
    logic term;
    logic tmo;
    logic wait_hit;

    assign sz  = bus.req_funct3[1:0];
    assign uns = bus.req_funct3[2];
    assign off = bus.alu_result[OW-1:0];

    // natural-alignment mask of the access size (B:0, H:1, W:3, D:7)
    assign amask   = OW'((8'd1 << sz) - 8'd1);
    assign aoff    = off & ~amask;
    assign be_base = NB'((16'd1 << (16'd1 << sz)) - 16'd1);
    assign be_nx   = be_base << aoff;
    assign addr_nx = bus.alu_result & ~WIDTH'(NB - 1);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = |(off & amask);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        illegal = 1'b0;
        if (bus.req_funct3 == 3'b111)
            illegal = 1'b1;
        // stores only exist for funct3 000..011
        if (bus.req_write && bus.req_funct3[2])
            illegal = 1'b1;
        // D and WU need a 64-bit datapath
        if (WIDTH == 32 && (sz == 2'd3 || bus.req_funct3 == 3'b110))
            illegal = 1'b1;
    end

    always_comb begin
        unique case (sz)
            2'd0:    wdata_nx = {NB{bus.write_data[7:0]}};
            2'd1:    wdata_nx = {(NB/2){bus.write_data[15:0]}};
            2'd2:    wdata_nx = {(WIDTH/32){bus.write_data[31:0]}};
            default: wdata_nx = bus.write_data;
        endcase
    end

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        unique case (sz_q)
            2'd0: begin
                lmask = M_B;
                lsign = shifted[7];
            end
            2'd1: begin
                lmask = M_H;
                lsign = shifted[15];
            end
            2'd2: begin
                lmask = M_W;
                lsign = shifted[31];
            end
            default: begin
                lmask = '1;
                lsign = 1'b0;
            end
        endcase
    end

    assign ldata = (lsign && !uns_q) ? (shifted | ~lmask)
                                     : (shifted & lmask);

    assign wait_hit = (MAX_WAIT != 0) && (int'(wcnt) == MAX_WAIT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        term           = 1'b0;
        tmo            = 1'b0;
        bus.req_ready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = (illegal || trap) ? RESP : BUS;
                end
            end
            BUS: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack || bus.mem_err) begin
                    term     = 1'b1;
                    state_nx = RESP;
                end else if (wait_hit) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            sz_q    <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            wcnt    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            be_q    <= be_nx;
            we_q    <= bus.req_write;
            sz_q    <= sz;
            uns_q   <= uns;
            off_q   <= aoff;
            wcnt    <= '0;
            err_q   <= illegal | trap;
            rdata_q <= '0;
        end else if (term) begin
            // mem_err dominates a simultaneous mem_ack
            err_q   <= bus.mem_err;
            rdata_q <= (bus.mem_err || we_q) ? '0 : ldata;
        end else if (tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
        end else if (state == BUS) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_be     = bus.mem_req ? be_q : '0;
    assign bus.mem_we     = bus.mem_req & we_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl (WIDTH=32, MAX_WAIT=4).
// Stimulus queues expected bus/response items; monitors pop and compare.
module tb_lsu_mem_ctrl;
    localparam int MAXW   = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          waits;
        int          kind;
        int          len;
    } plan_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    plan_t plan_q[$];
    exp_t  resp_q[$];

    lsu_mem_ctrl_if #(.WIDTH(32)) b ();

    lsu_mem_ctrl #(
        .WIDTH(32),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: derived from the size/offset rules with plain arithmetic.
    function automatic void model(
        input bit wr, input bit [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic [31:0] rd, input int waits, input int kind,
        output bit use_bus, output plan_t p, output exp_t e);
        int     n;
        int     off;
        int     aoff;
        bit     illegal;
        bit     trap;
        longint v;
        longint lim;
        n       = 1 << f3[1:0];
        off     = int'(addr[1:0]);
        aoff    = off - (off % n);
        illegal = (f3 == 3'd7) || (f3 == 3'd6) ||
                  (f3[1:0] == 2'd3) || (wr && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (off % n) != 0;
`else
        trap = 1'b0;
`endif
        p.we    = wr;
        p.addr  = {addr[31:2], 2'b00};
        p.be    = 4'(((1 << n) - 1) << aoff);
        p.rdata = rd;
        p.waits = waits;
        p.kind  = kind;
        p.len   = (kind == K_NONE) ? MAXW : waits + 1;
        for (int i = 0; i < 4; i++)
            p.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        e.acc   = 0;
        e.err   = 1'b1;
        e.rdata = '0;
        e.lat   = 1;
        use_bus = !(illegal || trap);
        if (use_bus) begin
            e.lat = (kind == K_NONE) ? MAXW + 1 : waits + 2;
            if (kind == K_ACK) begin
                e.err = 1'b0;
                if (!wr) begin
                    v       = 0;
                    v[31:0] = rd >> (8 * aoff);
                    lim     = 64'd1 << (8 * n);
                    v       = v % lim;
                    if (!f3[2] && v >= lim / 2)
                        v = v - lim;
                    e.rdata = v[31:0];
                end
            end
        end
    endfunction

    // response monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (b.resp_valid) begin
            if (resp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got resp_valid=1 want 0");
            end else begin
                e = resp_q.pop_front();
                chk("resp_err", b.resp_err, e.err);
                chk("resp_rdata", b.resp_rdata, e.rdata);
                chk("resp_latency", cyc - e.acc + 1, e.lat);
                chk("ready_in_resp", b.req_ready, 0);
            end
        end
    end

    // memory device model and bus-side checker
    initial begin : mem
        plan_t cur;
        int    left;
        int    len;
        bit    in_txn;
        b.mem_ack   = 1'b0;
        b.mem_err   = 1'b0;
        b.mem_rdata = '0;
        in_txn      = 1'b0;
        left        = 0;
        len         = 0;
        cur.kind    = K_ACK;
        cur.waits   = 0;
        cur.len     = 1;
        cur.we      = 1'b0;
        forever begin
            @(negedge clk);
            if (b.mem_req) begin
                if (!in_txn) begin
                    if (plan_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mem_req_unexpected: got 1 want 0");
                        cur.kind  = K_ACK;
                        cur.waits = 0;
                        cur.len   = 1;
                    end else begin
                        cur = plan_q.pop_front();
                        chk("mem_addr", b.mem_addr, cur.addr);
                        chk("mem_we", b.mem_we, cur.we);
                        chk("mem_be", b.mem_be, cur.be);
                        if (cur.we)
                            chk("mem_wdata", b.mem_wdata, cur.wdata);
                    end
                    in_txn = 1'b1;
                    left   = cur.waits;
                    len    = 0;
                end
                len++;
                b.mem_ack   = 1'b0;
                b.mem_err   = 1'b0;
                b.mem_rdata = $urandom;
                if (cur.kind != K_NONE && left == 0) begin
                    b.mem_ack   = (cur.kind != K_ERR);
                    b.mem_err   = (cur.kind != K_ACK);
                    b.mem_rdata = cur.rdata;
                end else if (left > 0) begin
                    left--;
                end
            end else begin
                if (in_txn && !rst)
                    chk("mem_req_len", len, cur.len);
                in_txn = 1'b0;
                // stray completions outside BUS must be ignored
                b.mem_ack   = ($urandom % 4) == 0;
                b.mem_err   = ($urandom % 8) == 0;
                b.mem_rdata = $urandom;
            end
        end
    end

    task automatic junk_req();
        b.req_write  = 1'($urandom);
        b.req_funct3 = 3'($urandom);
        b.alu_result = $urandom;
        b.write_data = $urandom;
    endtask

    task automatic issue(input bit wr, input bit [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int waits, input int kind);
        plan_t p;
        exp_t  e;
        bit    ub;
        int    n;
        model(wr, f3, addr, wd, rd, waits, kind, ub, p, e);
        n = 0;
        while (!b.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_ready_idle", b.req_ready, 1);
        b.req_valid  = 1'b1;
        b.req_write  = wr;
        b.req_funct3 = f3;
        b.alu_result = addr;
        b.write_data = wd;
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        junk_req();
        e.acc = cyc;
        if (ub)
            plan_q.push_back(p);
        resp_q.push_back(e);
        n = 0;
        while (resp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (resp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no resp want resp_valid");
            resp_q.delete();
            plan_q.delete();
        end
    endtask

    initial begin : stim
        plan_t p;
        exp_t  e;
        bit    ub;
        rst         = 1'b1;
        b.req_valid = 1'b0;
        junk_req();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", b.req_ready, 1);
        chk("rst_mem_req", b.mem_req, 0);
        chk("rst_resp_valid", b.resp_valid, 0);
        chk("rst_resp_err", b.resp_err, 0);
        chk("rst_resp_rdata", b.resp_rdata, 0);
        chk("rst_mem_be", b.mem_be, 0);
        chk("rst_mem_we", b.mem_we, 0);
        rst = 1'b0;

        issue(1, 3'b010, 32'h10, 32'hDEADBEEF, $urandom, 0, K_ACK);
        issue(1, 3'b000, 32'h13, 32'h000000A5, $urandom, 0, K_ACK);
        issue(1, 3'b001, 32'h16, 32'h00001234, $urandom, 1, K_ACK);
        issue(0, 3'b000, 32'h12, $urandom, 32'h0080FF00, 0, K_ACK);
        issue(0, 3'b100, 32'h12, $urandom, 32'h0080FF00, 0, K_ACK);
        issue(0, 3'b101, 32'h12, $urandom, 32'h0080FF00, 0, K_ACK);
        issue(0, 3'b001, 32'h12, $urandom, 32'h8001FF00, 2, K_ACK);
        issue(0, 3'b010, 32'h40, $urandom, 32'h12345678, 3, K_ACK);
        issue(0, 3'b010, 32'h44, $urandom, $urandom, 0, K_NONE);
        issue(0, 3'b001, 32'h11, $urandom, 32'hCAFEF00D, 1, K_ACK);
        issue(0, 3'b010, 32'h48, $urandom, $urandom, 1, K_BOTH);
        issue(1, 3'b010, 32'h4C, $urandom, $urandom, 0, K_ERR);
        issue(0, 3'b011, 32'h50, $urandom, $urandom, 0, K_ACK);
        issue(0, 3'b110, 32'h54, $urandom, $urandom, 0, K_ACK);
        issue(0, 3'b111, 32'h58, $urandom, $urandom, 0, K_ACK);
        issue(1, 3'b100, 32'h5C, $urandom, $urandom, 0, K_ACK);
        issue(1, 3'b011, 32'h60, $urandom, $urandom, 0, K_ACK);

        for (int i = 0; i < 150; i++) begin
            int k;
            int r;
            r = int'($urandom % 20);
            k = (r < 13) ? K_ACK : (r < 15) ? K_ERR :
                (r < 17) ? K_BOTH : K_NONE;
            issue(1'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, int'($urandom % 4), k);
        end

        // reset while a load is stalled on the bus
        model(0, 3'b010, 32'h80, 32'h0, 32'h0, 3, K_ACK, ub, p, e);
        b.req_valid  = 1'b1;
        b.req_write  = 1'b0;
        b.req_funct3 = 3'b010;
        b.alu_result = 32'h80;
        plan_q.push_back(p);
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        junk_req();
        @(posedge clk);
        #1;
        chk("busy_before_rst", b.mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_mem_req", b.mem_req, 0);
        chk("rst_drop_resp", b.resp_valid, 0);
        chk("rst_drop_ready", b.req_ready, 1);
        chk("rst_drop_be", b.mem_be, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 3'b000, 32'h87, $urandom, 32'h7F000000, 0, K_ACK);

        repeat (5) @(posedge clk);
        #1;
        chk("resp_q_drained", resp_q.size(), 0);
        chk("plan_q_drained", plan_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
